apu_mem_arbiter: RTL and testbench

Shares one memory/BRAM port between N_REQ APU cores running different audio channels.
- Each core's level-held fetch/load/store request is granted round-robin and forwarded unchanged, including its address and RAM/BRAM select.
- The single completion (ready or write-ack) is returned to the granted core as a one-cycle pulse.
- A per-transaction timeout guarantees forward progress if memory never answers.

---
 rtl/apu_mem_arbiter_pkg.sv | 20 ++
 rtl/apu_mem_arbiter_if.sv | 43 ++++
 rtl/apu_mem_arbiter_rr_pick.sv | 34 +++
 rtl/apu_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_apu_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apu_mem_arbiter_pkg.sv
// Shared types and widths for the APU memory arbiter slice.
package apu_mem_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 16;

   // Arbiter FSM: wait for a request, hold the memory strobe, pulse the response.
   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   // Operation latched for the granted requester.
   typedef enum logic {
      OP_READ,
      OP_WRITE
   } op_e;

endpackage

// File: rtl/apu_mem_arbiter_if.sv
// Requester-side and memory-side bus of the APU memory arbiter.
// master = the arbiter itself, slave = the cores plus the memory around it.
interface apu_mem_arbiter_if #(
   parameter int N_REQ = 4
);
   import apu_mem_pkg::*;

   // Requester side, one slice per APU core
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_re;
   logic [N_REQ-1:0]        req_we;
   logic [N_REQ-1:0]        req_ram;
   logic [DATA_W-1:0]       req_rdata;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        req_wack;
   logic [N_REQ-1:0]        timeout_flag;

   // Memory side, single shared port
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic                    mem_re;
   logic                    mem_we;
   logic                    mem_ram;
   logic [DATA_W-1:0]       mem_rdata;
   logic                    mem_ready;
   logic                    mem_wack;

   modport master (
      input  req_addr, req_wdata, req_re, req_we, req_ram,
      input  mem_rdata, mem_ready, mem_wack,
      output req_rdata, req_ready, req_wack, timeout_flag,
      output mem_addr, mem_wdata, mem_re, mem_we, mem_ram
   );

   modport slave (
      output req_addr, req_wdata, req_re, req_we, req_ram,
      output mem_rdata, mem_ready, mem_wack,
      input  req_rdata, req_ready, req_wack, timeout_flag,
      input  mem_addr, mem_wdata, mem_re, mem_we, mem_ram
   );

endinterface

// File: rtl/apu_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after the
// pointer, wrapping modulo N_REQ.
module rr_pick #(
   parameter  int N_REQ = 4,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // Scan N_REQ candidates starting at the pointer; the first hit wins.
   always_comb begin
      int cand;
      // NOTE: every output gets a default before the loop, so no path leaves
      // a value unassigned and no latch is inferred.
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = int'(ptr_i) + off;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
            grant_o[cand[IDX_W-1:0]] = 1'b1;
            idx_o                    = cand[IDX_W-1:0];
            valid_o                  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apu_mem_arbiter.sv
// Shares one memory/BRAM port between N_REQ APU cores. One transaction is
// outstanding at a time; the completion comes back to the granted core as a
// one-cycle pulse, and a timeout forces completion if memory never answers.
module apu_mem_arbiter
   import apu_mem_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   apu_mem_arbiter_if.master bus
);

   localparam int              IDX_W    = $clog2(N_REQ);
   localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit              TMO_EN   = (TIMEOUT > 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   // Arbitration inputs
   logic [N_REQ-1:0]  req_any;
   logic [N_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_valid;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_ram;
   logic              sel_we;

   // FSM state and latched transaction
   state_e            state_q;
   op_e               op_q;
   logic [IDX_W-1:0]  winner_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  tmo_cnt_q;
   logic [N_REQ-1:0]  winner_oh;
   logic              mem_done;
   logic              tmo_hit;

   // Registered outputs
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_re_q;
   logic              mem_we_q;
   logic              mem_ram_q;
   logic [DATA_W-1:0] req_rdata_q;
   logic [N_REQ-1:0]  req_ready_q;
   logic [N_REQ-1:0]  req_wack_q;
   logic [N_REQ-1:0]  timeout_flag_q;

   // A core is requesting on either strobe; a write wins over a read.
   assign req_any = bus.req_re | bus.req_we;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req_i   (req_any),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Steer the winning core's address, data, target and op with the one-hot grant.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_ram   = 1'b0;
      sel_we    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_grant[i]) begin
            sel_addr  = bus.req_addr[ADDR_W*i +: ADDR_W];
            sel_wdata = bus.req_wdata[DATA_W*i +: DATA_W];
            sel_ram   = bus.req_ram[i];
            sel_we    = bus.req_we[i];
         end
      end
   end

   // Only the completion matching the latched op ends the transaction.
   assign mem_done  = (op_q == OP_WRITE) ? bus.mem_wack : bus.mem_ready;
   assign tmo_hit   = TMO_EN && (tmo_cnt_q == CNT_W'(TIMEOUT));
   assign winner_oh = N_REQ'(1) << winner_q;

   // Arbiter FSM with all outputs registered; synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples pre-edge values regardless of statement order.
         state_q        <= IDLE;
         op_q           <= OP_READ;
         winner_q       <= '0;
         ptr_q          <= '0;
         tmo_cnt_q      <= '0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_re_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_ram_q      <= 1'b0;
         req_rdata_q    <= '0;
         req_ready_q    <= '0;
         req_wack_q     <= '0;
         timeout_flag_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  winner_q    <= pick_idx;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  mem_ram_q   <= sel_ram;
                  op_q        <= sel_we ? OP_WRITE : OP_READ;
                  mem_re_q    <= !sel_we;
                  mem_we_q    <= sel_we;
                  tmo_cnt_q   <= '0;
                  state_q     <= BUSY;
               end
            end
            BUSY: begin
               if (mem_done || tmo_hit) begin
                  mem_re_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if (op_q == OP_READ) begin
                     req_ready_q <= winner_oh;
                     // A forced completion returns zero, never stale bus data.
                     req_rdata_q <= mem_done ? bus.mem_rdata : '0;
                  end else begin
                     req_wack_q <= winner_oh;
                  end
                  if (!mem_done) timeout_flag_q[winner_q] <= 1'b1;
                  state_q <= RESP;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            RESP: begin
               req_ready_q <= '0;
               req_wack_q  <= '0;
               ptr_q       <= (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.mem_re       = mem_re_q;
   assign bus.mem_we       = mem_we_q;
   assign bus.mem_ram      = mem_ram_q;
   assign bus.req_rdata    = req_rdata_q;
   assign bus.req_ready    = req_ready_q;
   assign bus.req_wack     = req_wack_q;
   assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_apu_mem_arbiter.sv
// Scoreboard bench for apu_mem_arbiter: stimulus pushes the expected memory
// transaction and core response; a monitor pops and compares them whenever
// the DUT raises a memory strobe or a response pulse.
module tb_apu_mem_arbiter;
   import apu_mem_pkg::*;

   localparam int N = 4;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [15:0] wdata;
      logic        ram;
   } mem_exp_t;

   typedef struct {
      logic        wr;
      int          idx;
      logic [15:0] rdata;
   } rsp_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   mem_exp_t exp_mem[$];
   rsp_exp_t exp_rsp[$];

   apu_mem_arbiter_if #(.N_REQ(N)) bus ();

   apu_mem_arbiter #(
      .N_REQ   (N),
      .TIMEOUT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic        prev_strobe = 1'b0;
   logic [31:0] hold_addr   = '0;
   mem_exp_t    m;
   rsp_exp_t    r;

   // Compare each new memory transaction and each response pulse with the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if ((bus.mem_re || bus.mem_we) && !prev_strobe) begin
            if (exp_mem.size() == 0) begin
               check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               m = exp_mem.pop_front();
               check("mem_we", 32'(bus.mem_we), 32'(m.wr));
               check("mem_re", 32'(bus.mem_re), 32'(!m.wr));
               check("mem_addr", bus.mem_addr, m.addr);
               check("mem_ram", 32'(bus.mem_ram), 32'(m.ram));
               if (m.wr) check("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
               hold_addr <= m.addr;
            end
         end else if (bus.mem_re || bus.mem_we) begin
            check("mem_addr_hold", bus.mem_addr, hold_addr);
         end
         if (|bus.req_ready || |bus.req_wack) begin
            if (exp_rsp.size() == 0) begin
               check("unexpected_pulse", {24'd0, bus.req_ready, bus.req_wack}, 32'd0);
            end else begin
               r = exp_rsp.pop_front();
               check("req_ready", 32'(bus.req_ready), r.wr ? 32'd0 : (32'd1 << r.idx));
               check("req_wack", 32'(bus.req_wack), r.wr ? (32'd1 << r.idx) : 32'd0);
               if (!r.wr) check("req_rdata", 32'(bus.req_rdata), 32'(r.rdata));
            end
         end
      end
      prev_strobe <= bus.mem_re || bus.mem_we;
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_all();
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_re    = '0;
      bus.req_we    = '0;
      bus.req_ram   = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      bus.mem_wack  = 1'b0;
   endtask

   task automatic set_req(input int i, input logic re, input logic we,
                          input logic [31:0] addr, input logic [15:0] wd, input logic ram);
      bus.req_addr[32*i +: 32]  = addr;
      bus.req_wdata[16*i +: 16] = wd;
      bus.req_re[i]             = re;
      bus.req_we[i]             = we;
      bus.req_ram[i]            = ram;
   endtask

   task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [15:0] wd, input logic ram);
      mem_exp_t e;
      e.wr = wr; e.addr = addr; e.wdata = wd; e.ram = ram;
      exp_mem.push_back(e);
   endtask

   task automatic push_rsp(input logic wr, input int idx, input logic [15:0] rd);
      rsp_exp_t e;
      e.wr = wr; e.idx = idx; e.rdata = rd;
      exp_rsp.push_back(e);
   endtask

   // Wait (bounded) for the DUT to raise a memory strobe.
   task automatic wait_strobe();
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.mem_re || bus.mem_we) seen = 1'b1;
      end
      if (!seen) check("strobe_wait", 32'd0, 32'd1);
   endtask

   // Answer the current transaction on the lat-th cycle of the strobe.
   task automatic complete(input int lat, input bit wr, input logic [15:0] d);
      repeat (lat - 1) @(negedge clk);
      bus.mem_rdata = d;
      if (wr) bus.mem_wack = 1'b1;
      else    bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_wack  = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int idx;
      int n;
      bit got;

      idle_all();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mem_strobe", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata_ram", {15'd0, bus.mem_ram, bus.mem_wdata}, 32'd0);
      check("rst_req_pulses", {24'd0, bus.req_ready, bus.req_wack}, 32'd0);
      check("rst_req_rdata", 32'(bus.req_rdata), 32'd0);
      check("rst_timeout_flag", 32'(bus.timeout_flag), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Round robin from pointer 0: all four reads held, one-cycle memory.
      for (int i = 0; i < N; i++) begin
         idx = i;
         set_req(i, 1'b1, 1'b0, 32'h100 * (i + 1), 16'h0, idx[0]);
      end
      for (int k = 0; k < 8; k++) begin
         idx = k % N;
         push_mem(1'b0, 32'h100 * (idx + 1), 16'h0, idx[0]);
         push_rsp(1'b0, idx, 16'(16'hA000 + k));
      end
      for (int k = 0; k < 8; k++) begin
         wait_strobe();
         complete(1, 1'b0, 16'(16'hA000 + k));
      end
      idle_all();
      repeat (2) @(negedge clk);

      // Single read from core 1, RAM target, three-cycle memory.
      set_req(1, 1'b1, 1'b0, 32'h0000_0010, 16'h0, 1'b1);
      push_mem(1'b0, 32'h10, 16'h0, 1'b1);
      push_rsp(1'b0, 1, 16'hBEEF);
      wait_strobe();
      complete(3, 1'b0, 16'hBEEF);
      idle_all();
      repeat (2) @(negedge clk);

      // Write from core 2 with a stray mem_ready before the real mem_wack.
      set_req(2, 1'b0, 1'b1, 32'h0754, 16'h1234, 1'b0);
      push_mem(1'b1, 32'h0754, 16'h1234, 1'b0);
      push_rsp(1'b1, 2, 16'h0);
      wait_strobe();
      bus.mem_rdata = 16'hDEAD;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_wack  = 1'b1;
      @(negedge clk);
      bus.mem_wack  = 1'b0;
      idle_all();
      repeat (2) @(negedge clk);

      // Timeout on core 3: memory silent, forced completion with zero data.
      set_req(3, 1'b1, 1'b0, 32'h20, 16'h0, 1'b0);
      bus.mem_rdata = 16'h5555;
      push_mem(1'b0, 32'h20, 16'h0, 1'b0);
      push_rsp(1'b0, 3, 16'h0000);
      wait_strobe();
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.req_ready[3]) got = 1'b1;
      end
      check("timeout_latency", 32'(n), 32'd9);
      idle_all();
      check("timeout_flag_set", 32'(bus.timeout_flag), 32'b1000);
      repeat (2) @(negedge clk);

      // Core 3 is served normally after its timeout; the flag stays set.
      set_req(3, 1'b1, 1'b0, 32'h24, 16'h0, 1'b0);
      push_mem(1'b0, 32'h24, 16'h0, 1'b0);
      push_rsp(1'b0, 3, 16'h7777);
      wait_strobe();
      complete(2, 1'b0, 16'h7777);
      idle_all();
      check("timeout_flag_sticky", 32'(bus.timeout_flag), 32'b1000);
      repeat (2) @(negedge clk);

      // Read and write together on core 0: the write wins.
      set_req(0, 1'b1, 1'b1, 32'h40, 16'hCAFE, 1'b1);
      push_mem(1'b1, 32'h40, 16'hCAFE, 1'b1);
      push_rsp(1'b1, 0, 16'h0);
      wait_strobe();
      complete(1, 1'b1, 16'h0);
      idle_all();
      repeat (2) @(negedge clk);

      // Read from core 2 moves the pointer to 3.
      set_req(2, 1'b1, 1'b0, 32'h80, 16'h0, 1'b0);
      push_mem(1'b0, 32'h80, 16'h0, 1'b0);
      push_rsp(1'b0, 2, 16'h2222);
      wait_strobe();
      complete(2, 1'b0, 16'h2222);
      idle_all();
      repeat (2) @(negedge clk);

      // Reset while core 3 is in BUSY; a late mem_ready must be ignored.
      set_req(3, 1'b1, 1'b0, 32'hC0, 16'h0, 1'b1);
      push_mem(1'b0, 32'hC0, 16'h0, 1'b1);
      wait_strobe();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstbusy_mem_re", 32'(bus.mem_re), 32'd0);
      check("rstbusy_mem_addr", bus.mem_addr, 32'd0);
      check("rstbusy_req_ready", 32'(bus.req_ready), 32'd0);
      check("rstbusy_timeout_flag", 32'(bus.timeout_flag), 32'd0);
      rst = 1'b0;
      idle_all();
      bus.mem_rdata = 16'h9999;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Pointer is back at 0: with cores 1 and 3 requesting, core 1 wins.
      set_req(1, 1'b1, 1'b0, 32'h11, 16'h0, 1'b0);
      set_req(3, 1'b1, 1'b0, 32'h33, 16'h0, 1'b1);
      push_mem(1'b0, 32'h11, 16'h0, 1'b0);
      push_rsp(1'b0, 1, 16'h1111);
      wait_strobe();
      complete(1, 1'b0, 16'h1111);
      idle_all();
      repeat (5) @(negedge clk);

      check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
      check("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
